// File: rtl/pe_unit.sv
// pe_unit: output-stationary systolic PE -- multiply-accumulate up_i*left_i into res_o, forward operands registered
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears all outputs
//   up_i    : column operand from PE above      -> down_o  (1-cycle registered copy)
//   left_i  : row operand from PE to the left   -> right_o (1-cycle registered copy)
//   res_o   : running unsigned sum of products, wraps modulo 2^ACC_WIDTH
module pe_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] up_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  output logic [DATA_WIDTH-1:0] down_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic [ACC_WIDTH-1:0]  res_o
);
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   r_down;
  logic [DATA_WIDTH-1:0]   r_right;
  logic [ACC_WIDTH-1:0]    r_res;
  // full-width product: operands are extended to 2*DATA_WIDTH by the assignment context
  assign w_prod = up_i * left_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_down  <= '0;
      r_right <= '0;
      r_res   <= '0;
    end else begin
      r_down  <= up_i;
      r_right <= left_i;
      r_res   <= r_res + ACC_WIDTH'(w_prod);
    end
  assign down_o  = r_down;
  assign right_o = r_right;
  assign res_o   = r_res;
endmodule

// File: tb/tb_pe_unit.sv
// tb_pe_unit: directed self-checking bench for pe_unit
module tb_pe_unit;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic [31:0] up_i = '0;
  logic [31:0] left_i = '0;
  logic [31:0] down_o;
  logic [31:0] right_o;
  logic [63:0] res_o;
  int checks = 0;
  int failures = 0;

  pe_unit #(.DATA_WIDTH(32), .ACC_WIDTH(64)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .up_i(up_i), .left_i(left_i),
    .down_o(down_o), .right_o(right_o), .res_o(res_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] u, input logic [31:0] l);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    up_i = u;
    left_i = l;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_ni = 1'b0;
    up_i = 32'd5;
    left_i = 32'd3;
    #1;
    checks++;
    if ({res_o, down_o, right_o} !== 128'd0) begin
      failures++;
      $display("FAIL reset_async res=%h down=%h right=%h expected all 0", res_o, down_o, right_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({res_o, down_o, right_o} !== 128'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d] res=%h down=%h right=%h expected all 0", i, res_o, down_o, right_o);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [63:0] exp_res [3] = '{64'd15, 64'd30, 64'd45};
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (res_o !== exp_res[i] || down_o !== 32'd5 || right_o !== 32'd3) begin
        failures++;
        $display("FAIL accumulate[%0d] res=%0d down=%0d right=%0d expected res=%0d down=5 right=3",
                 i, res_o, down_o, right_o, exp_res[i]);
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] u [4] = '{32'd2, 32'd4, 32'd0, 32'd6};
    logic [31:0] l [4] = '{32'd7, 32'd1, 32'd9, 32'd6};
    logic [63:0] e [4] = '{64'd14, 64'd18, 64'd18, 64'd54};
    do_reset(u[0], l[0]);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        up_i = u[i];
        left_i = l[i];
      end
      step();
      checks++;
      if (res_o !== e[i] || down_o !== u[i] || right_o !== l[i]) begin
        failures++;
        $display("FAIL stream[%0d] res=%0d down=%0d right=%0d expected res=%0d down=%0d right=%0d",
                 i, res_o, down_o, right_o, e[i], u[i], l[i]);
      end
    end
  endtask

  task automatic test_overflow_wrap();
    logic [63:0] e [5] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFC_0000_0002,
                           64'hFFFF_FFFA_0000_0003, 64'hFFFF_FFF8_0000_0004,
                           64'hFFFF_FFF8_0000_0005};
    logic [31:0] o [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    do_reset(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        up_i = o[i];
        left_i = o[i];
      end
      step();
      checks++;
      if (res_o !== e[i] || down_o !== o[i] || right_o !== o[i]) begin
        failures++;
        $display("FAIL wrap[%0d] res=%h down=%h right=%h expected res=%h down=right=%h",
                 i, res_o, down_o, right_o, e[i], o[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(32'd5, 32'd3);
    step();
    step();
    checks++;
    if (res_o !== 64'd30) begin
      failures++;
      $display("FAIL midreset_pre res=%0d expected 30", res_o);
    end
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({res_o, down_o, right_o} !== 128'd0) begin
      failures++;
      $display("FAIL midreset_async res=%h down=%h right=%h expected all 0", res_o, down_o, right_o);
    end
    step();
    checks++;
    if ({res_o, down_o, right_o} !== 128'd0) begin
      failures++;
      $display("FAIL midreset_hold res=%h down=%h right=%h expected all 0", res_o, down_o, right_o);
    end
    @(negedge clk);
    up_i = 32'd5;
    left_i = 32'd3;
    rst_ni = 1'b1;
    step();
    checks++;
    if (res_o !== 64'd15 || down_o !== 32'd5 || right_o !== 32'd3) begin
      failures++;
      $display("FAIL midreset_resume res=%0d down=%0d right=%0d expected res=15 down=5 right=3",
               res_o, down_o, right_o);
    end
    @(negedge clk);
    up_i = 32'd0;
    left_i = 32'd100;
    step();
    checks++;
    if (res_o !== 64'd15 || down_o !== 32'd0 || right_o !== 32'd100) begin
      failures++;
      $display("FAIL zero_up res=%0d down=%0d right=%0d expected res=15 down=0 right=100",
               res_o, down_o, right_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] u [3] = '{32'd10, 32'd0, 32'd3};
    logic [31:0] l [3] = '{32'd0, 32'd11, 32'd1000};
    logic [63:0] e [3] = '{64'd15, 64'd15, 64'd3015};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      up_i = u[i];
      left_i = l[i];
      step();
      checks++;
      if (res_o !== e[i] || down_o !== u[i] || right_o !== l[i]) begin
        failures++;
        $display("FAIL back_to_back[%0d] res=%0d down=%0d right=%0d expected res=%0d down=%0d right=%0d",
                 i, res_o, down_o, right_o, e[i], u[i], l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_stream();
    test_overflow_wrap();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
